// File: rtl/irrigation_pkg.sv
// rtl/irrigation_pkg.sv - shared state encoding and timing defaults for the irrigation scheduler
package irrigation_pkg;

  // estado encoding, also decoded by the 7-segment display path
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SPRINKLE = 3'd1,
    DRIP     = 3'd2,
    REST     = 3'd3,
    FAULT    = 3'd4
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_MIN_ON_CYCLES   = 8;
  localparam int DEF_MAX_ON_CYCLES   = 64;
  localparam int DEF_REST_CYCLES     = 16;
  localparam int DEF_FILL_TIMEOUT    = 128;

  // A wet upper sensor above a dry lower one cannot happen with a real water column
  function automatic logic level_inconsistent(input logic h, input logic m, input logic l);
    return (h & ~m) | (m & ~l) | (h & ~l);
  endfunction

endpackage

// File: rtl/sensor_debouncer.sv
// rtl/sensor_debouncer.sv - two-flop synchronizer followed by a consecutive-sample debouncer
module sensor_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_deb
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_deb;
  logic [CW-1:0] r_cnt;

  // Synchronize, then accept the new level only after it has held for DEBOUNCE_CYCLES samples
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_deb <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_deb = r_deb;

endmodule

// File: rtl/irrigation_scheduler.sv
// rtl/irrigation_scheduler.sv - tank fill and irrigation valve controller with sensor conditioning
module irrigation_scheduler
  import irrigation_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int MIN_ON_CYCLES   = DEF_MIN_ON_CYCLES,
  parameter int MAX_ON_CYCLES   = DEF_MAX_ON_CYCLES,
  parameter int REST_CYCLES     = DEF_REST_CYCLES,
  parameter int FILL_TIMEOUT    = DEF_FILL_TIMEOUT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       high,
  input  logic       middle,
  input  logic       low,
  input  logic       umidadeDoSolo,
  input  logic       umidadeDoAr,
  input  logic       temperatura,
  output logic       erro,
  output logic       saidaDoAlarme,
  output logic       ValvulaDeEntrada,
  output logic       ValvulaDeAspersao,
  output logic       ValvulaDeGotejamento,
  output logic       falhaEnchimento,
  output logic [2:0] estado
);

  localparam int RUN_SPAN = (MAX_ON_CYCLES > REST_CYCLES) ? MAX_ON_CYCLES : REST_CYCLES;
  localparam int RUN_W    = (RUN_SPAN > 1) ? $clog2(RUN_SPAN) : 1;
  localparam int FILL_W   = (FILL_TIMEOUT > 1) ? $clog2(FILL_TIMEOUT) : 1;

  // Counters hold the number of cycles already spent, so "last" is the final allowed cycle
  localparam logic [RUN_W-1:0]  MIN_LAST  = RUN_W'(MIN_ON_CYCLES - 1);
  localparam logic [RUN_W-1:0]  MAX_LAST  = RUN_W'(MAX_ON_CYCLES - 1);
  localparam logic [RUN_W-1:0]  REST_LAST = RUN_W'(REST_CYCLES - 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FILL_TIMEOUT - 1);

  logic [5:0] w_raw;
  logic [5:0] w_deb;
  logic       w_high, w_middle, w_low, w_soil, w_air, w_temp;
  logic       w_erro;
  logic       w_fill_timeout;
  logic       w_run_done;

  state_t              r_state;
  logic [RUN_W-1:0]    r_run_cnt;
  logic [FILL_W-1:0]   r_fill_cnt;
  logic                r_erro, r_alarm, r_inlet, r_falha, r_asp, r_got;

  assign w_raw = {temperatura, umidadeDoAr, umidadeDoSolo, low, middle, high};

  for (genvar g = 0; g < 6; g++) begin : g_deb
    sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .i_clock (clock),
      .i_reset (reset),
      .i_raw   (w_raw[g]),
      .o_deb   (w_deb[g])
    );
  end

  assign {w_temp, w_air, w_soil, w_low, w_middle, w_high} = w_deb;

  assign w_erro         = level_inconsistent(w_high, w_middle, w_low) | r_falha;
  assign w_fill_timeout = r_inlet && (r_fill_cnt == FILL_LAST);
  assign w_run_done     = !w_low || (w_soil && (r_run_cnt >= MIN_LAST)) || (r_run_cnt == MAX_LAST);

  // Inlet hysteresis, fill watchdog with sticky fault flag, and registered error/alarm
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_inlet    <= 1'b0;
      r_falha    <= 1'b0;
      r_fill_cnt <= '0;
      r_erro     <= 1'b0;
      r_alarm    <= 1'b0;
    end else begin
      if (w_fill_timeout) begin
        r_falha <= 1'b1;
        r_inlet <= 1'b0;
      end else if (w_erro || w_high) begin
        r_inlet <= 1'b0;
      end else if (!w_middle) begin
        r_inlet <= 1'b1;
      end
      if (!r_inlet) begin
        r_fill_cnt <= '0;
      end else if (r_fill_cnt != '1) begin
        r_fill_cnt <= r_fill_cnt + 1'b1;
      end
      r_erro  <= w_erro;
      r_alarm <= ~w_low | w_erro;
    end
  end

  // Irrigation FSM; valve flops follow the next state so they drop on the exit edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_run_cnt <= '0;
      r_asp     <= 1'b0;
      r_got     <= 1'b0;
    end else begin
      if (r_run_cnt != '1) r_run_cnt <= r_run_cnt + 1'b1;
      case (r_state)
        IDLE: begin
          if (w_erro) begin
            r_state   <= FAULT;
            r_run_cnt <= '0;
          end else if (!w_soil && w_low) begin
            r_run_cnt <= '0;
            if (w_middle && !w_temp && !w_air) begin
              r_state <= SPRINKLE;
              r_asp   <= 1'b1;
            end else begin
              r_state <= DRIP;
              r_got   <= 1'b1;
            end
          end
        end
        SPRINKLE, DRIP: begin
          if (w_erro || w_run_done) begin
            r_state   <= w_erro ? FAULT : REST;
            r_run_cnt <= '0;
            r_asp     <= 1'b0;
            r_got     <= 1'b0;
          end
        end
        REST: begin
          if (w_erro) begin
            r_state   <= FAULT;
            r_run_cnt <= '0;
          end else if (r_run_cnt == REST_LAST) begin
            r_state   <= IDLE;
            r_run_cnt <= '0;
          end
        end
        FAULT: begin
          if (!w_erro) begin
            r_state   <= IDLE;
            r_run_cnt <= '0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_run_cnt <= '0;
          r_asp     <= 1'b0;
          r_got     <= 1'b0;
        end
      endcase
    end
  end

  assign erro                 = r_erro;
  assign saidaDoAlarme        = r_alarm;
  assign ValvulaDeEntrada     = r_inlet;
  assign ValvulaDeAspersao    = r_asp;
  assign ValvulaDeGotejamento = r_got;
  assign falhaEnchimento      = r_falha;
  assign estado               = r_state;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// tb/tb_irrigation_scheduler.sv - randomized and directed bench against a cycle-level reference model
module tb_irrigation_scheduler;

  localparam int DEB      = 4;
  localparam int MIN_ON   = 8;
  localparam int MAX_ON   = 64;
  localparam int REST_LEN = 16;
  localparam int FILL_TO  = 128;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic high = 1'b0, middle = 1'b0, low = 1'b0;
  logic umidadeDoSolo = 1'b0, umidadeDoAr = 1'b0, temperatura = 1'b0;
  logic erro, saidaDoAlarme, ValvulaDeEntrada, ValvulaDeAspersao, ValvulaDeGotejamento, falhaEnchimento;
  logic [2:0] estado;

  irrigation_scheduler dut (
    .clock                (clock),
    .reset                (reset),
    .high                 (high),
    .middle               (middle),
    .low                  (low),
    .umidadeDoSolo        (umidadeDoSolo),
    .umidadeDoAr          (umidadeDoAr),
    .temperatura          (temperatura),
    .erro                 (erro),
    .saidaDoAlarme        (saidaDoAlarme),
    .ValvulaDeEntrada     (ValvulaDeEntrada),
    .ValvulaDeAspersao    (ValvulaDeAspersao),
    .ValvulaDeGotejamento (ValvulaDeGotejamento),
    .falhaEnchimento      (falhaEnchimento),
    .estado               (estado)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state: sensor pipeline as plain bit arrays, controller as integers
  bit [5:0] m_s1, m_s2, m_deb;
  int       m_stable [6];
  bit       m_inlet, m_falha, m_erro, m_alarm, m_asp, m_got;
  int       m_open;
  int       m_state;
  int       m_in_state;

  function automatic logic [5:0] pat(input bit h, input bit m, input bit l,
                                     input bit s, input bit a, input bit t);
    return {t, a, s, l, m, h};
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_deb = '0;
    for (int i = 0; i < 6; i++) m_stable[i] = 0;
    m_inlet = 0; m_falha = 0; m_erro = 0; m_alarm = 0; m_asp = 0; m_got = 0;
    m_open = 0; m_state = 0; m_in_state = 0;
  endtask

  task automatic model_step();
    bit dh, dm, dl, ds, da, dt, e, was_open;
    int nxt;
    if (reset) begin
      model_reset();
      return;
    end
    {dt, da, ds, dl, dm, dh} = m_deb;
    e = ((dh & !dm) | (dm & !dl) | (dh & !dl)) | m_falha;
    m_erro  = e;
    m_alarm = !dl | e;
    was_open = m_inlet;
    if (m_inlet && m_open == FILL_TO - 1) begin
      m_falha = 1;
      m_inlet = 0;
    end else if (e || dh) begin
      m_inlet = 0;
    end else if (!dm) begin
      m_inlet = 1;
    end
    m_open = was_open ? m_open + 1 : 0;
    nxt = m_state;
    case (m_state)
      0: if (e) nxt = 4; else if (!ds && dl) nxt = (dm && !dt && !da) ? 1 : 2;
      1, 2: if (e) nxt = 4;
            else if (!dl || (ds && m_in_state + 1 >= MIN_ON) || m_in_state + 1 >= MAX_ON) nxt = 3;
      3: if (e) nxt = 4; else if (m_in_state + 1 >= REST_LEN) nxt = 0;
      default: if (!e) nxt = 0;
    endcase
    m_in_state = (nxt != m_state) ? 0 : m_in_state + 1;
    m_state = nxt;
    m_asp = (nxt == 1);
    m_got = (nxt == 2);
    for (int i = 0; i < 6; i++) begin
      if (m_s2[i] == m_deb[i]) begin
        m_stable[i] = 0;
      end else begin
        m_stable[i]++;
        if (m_stable[i] == DEB) begin
          m_deb[i] = m_s2[i];
          m_stable[i] = 0;
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = {temperatura, umidadeDoAr, umidadeDoSolo, low, middle, high};
  endtask

  task automatic compare_all();
    check_value("estado", estado, m_state);
    check_value("aspersao", ValvulaDeAspersao, m_asp);
    check_value("gotejamento", ValvulaDeGotejamento, m_got);
    check_value("entrada", ValvulaDeEntrada, m_inlet);
    check_value("falha", falhaEnchimento, m_falha);
    check_value("erro", erro, m_erro);
    check_value("alarme", saidaDoAlarme, m_alarm);
    check_value("valve_excl", ValvulaDeAspersao & ValvulaDeGotejamento, 0);
  endtask

  task automatic run_cycle(input logic [5:0] v, input logic rst);
    @(negedge clock);
    {temperatura, umidadeDoAr, umidadeDoSolo, low, middle, high} = v;
    reset = rst;
    @(posedge clock);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int len, rest_len, idle_bad;
    bit seen_end;
    int sel, hold;
    logic [5:0] v;
    model_reset();

    // Reset state
    for (int i = 0; i < 3; i++) run_cycle(pat(1, 1, 1, 1, 0, 0), 1);
    check_value("rst_estado", estado, 0);
    check_value("rst_valves", {ValvulaDeEntrada, ValvulaDeAspersao, ValvulaDeGotejamento}, 0);
    check_value("rst_flags", {erro, saidaDoAlarme, falhaEnchimento}, 0);

    // Full tank, wet soil: nothing runs
    for (int i = 0; i < 20; i++) run_cycle(pat(1, 1, 1, 1, 0, 0), 0);
    check_value("idle_estado", estado, 0);
    check_value("idle_valves", {ValvulaDeEntrada, ValvulaDeAspersao, ValvulaDeGotejamento}, 0);
    check_value("idle_flags", {erro, saidaDoAlarme}, 0);

    // Sprinkle run: soil dries for 5 cycles, so MIN_ON keeps the run alive
    len = 0; rest_len = 0;
    for (int i = 1; i <= 47; i++) begin
      run_cycle(pat(1, 1, 1, (i <= 5) ? 1'b0 : 1'b1, 0, 0), 0);
      if (i == 6) check_value("spr_latency_pre", estado, 0);
      if (i == 7) check_value("spr_latency", {estado, ValvulaDeAspersao}, {3'd1, 1'b1});
      if (ValvulaDeAspersao) len++;
      if (estado == 3'd3) rest_len++;
    end
    check_value("spr_len", len, MIN_ON);
    check_value("spr_rest_len", rest_len, REST_LEN);
    check_value("spr_back_idle", estado, 0);

    // Drip run held to MAX_ON
    len = 0; seen_end = 0;
    for (int i = 0; i < 120; i++) begin
      run_cycle(pat(1, 1, 1, 0, 0, 1), 0);
      if (!seen_end) begin
        if (ValvulaDeGotejamento) len++;
        else if (len > 0) begin
          seen_end = 1;
          check_value("drip_to_rest", estado, 3);
        end
      end
    end
    check_value("drip_ended", seen_end, 1);
    check_value("drip_len", len, MAX_ON);
    for (int i = 0; i < 50; i++) run_cycle(pat(1, 1, 1, 1, 0, 1), 0);

    // Inconsistent levels during a drip run
    for (int i = 0; i < 20; i++) run_cycle(pat(1, 1, 1, 0, 0, 1), 0);
    check_value("fault_pre_drip", estado, 2);
    for (int i = 1; i <= 10; i++) begin
      run_cycle(pat(1, 0, 1, 0, 0, 1), 0);
      if (i == 6) check_value("fault_pre", estado, 2);
      if (i == 7) begin
        check_value("fault_estado", estado, 4);
        check_value("fault_flags", {erro, saidaDoAlarme}, 2'b11);
        check_value("fault_valves", {ValvulaDeAspersao, ValvulaDeGotejamento}, 0);
      end
    end
    for (int i = 1; i <= 27; i++) begin
      run_cycle(pat(1, 1, 1, 1, 0, 0), 0);
      if (i == 6) check_value("recover_pre", estado, 4);
      if (i == 7) check_value("recover_idle", estado, 0);
    end

    // Fill timeout: middle dry, high never reached
    len = 0;
    for (int i = 0; i < 180; i++) begin
      run_cycle(pat(0, 0, 1, 1, 0, 0), 0);
      if (ValvulaDeEntrada) len++;
    end
    check_value("fill_open_len", len, FILL_TO);
    check_value("fill_flag", {falhaEnchimento, ValvulaDeEntrada, erro}, 3'b101);
    check_value("fill_estado", estado, 4);
    for (int i = 0; i < 20; i++) run_cycle(pat(1, 1, 1, 1, 0, 0), 0);
    check_value("fill_sticky", {falhaEnchimento, estado}, {1'b1, 3'd4});
    for (int i = 0; i < 2; i++) run_cycle(pat(1, 1, 1, 1, 0, 0), 1);
    check_value("fill_cleared", falhaEnchimento, 0);
    for (int i = 0; i < 10; i++) run_cycle(pat(1, 1, 1, 1, 0, 0), 0);

    // Soil bouncing every 2 cycles never starts a run
    idle_bad = 0;
    for (int i = 0; i < 30; i++) begin
      run_cycle(pat(1, 1, 1, ((i / 2) % 2) != 0, 0, 0), 0);
      if (estado != 3'd0) idle_bad++;
    end
    check_value("bounce_no_run", idle_bad, 0);

    // Reset in the middle of a sprinkle run
    for (int i = 0; i < 10; i++) run_cycle(pat(1, 1, 1, 0, 0, 0), 0);
    check_value("midrun_active", estado, 1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_value("midrun_async_valves", {ValvulaDeAspersao, ValvulaDeGotejamento, ValvulaDeEntrada}, 0);
    check_value("midrun_async_estado", estado, 0);
    model_reset();
    for (int i = 0; i < 2; i++) run_cycle(pat(1, 1, 1, 0, 0, 0), 1);
    for (int i = 0; i < 10; i++) run_cycle(pat(1, 1, 1, 1, 0, 0), 0);

    // Randomized segments of sensor patterns with occasional resets
    for (int seg = 0; seg < 200; seg++) begin
      sel  = $urandom_range(0, 9);
      hold = $urandom_range(1, 25);
      case (sel)
        0, 1:    v = pat(0, 0, 0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        2, 3:    v = pat(0, 0, 1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        4, 5:    v = pat(0, 1, 1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        6, 7, 8: v = pat(1, 1, 1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        default: v = 6'($urandom);
      endcase
      if ($urandom_range(0, 14) == 0) run_cycle(v, 1);
      for (int k = 0; k < hold; k++) run_cycle(v, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
